// File: rtl/detector_ganador.sv
// Connect-4 win/draw detector: snapshots the board on a rising FT and walks it one
// cell per clock, reporting the first four-in-a-row or a full-board draw.
module detector_ganador (
  input  logic            clk,
  input  logic            reset,
  input  logic            FT,
  input  logic [5:0][6:0] tablero,
  input  logic [5:0][6:0] fichas,
  output logic            busy,
  output logic            done,
  output logic            gano,
  output logic            ganador,
  output logic            empate,
  output logic [5:0][6:0] lineaGanadora
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state, state_nx;
  logic        ft_prev;
  logic [41:0] snap_tab, snap_fic;
  logic [5:0]  idx;
  logic [2:0]  row, col;
  logic        start, last_cell;

  logic [3:0][41:0] masks;
  logic [3:0]       line_ok;
  logic             hit, hit_owner;
  logic [41:0]      hit_mask;

  // Flat cell index is 7*row + col, matching the packed board layout, so every
  // candidate line is a fixed pattern shifted up to the current cell.
  assign masks[0] = 42'h000000F << idx;  // H
  assign masks[1] = 42'h0204081 << idx;  // V
  assign masks[2] = 42'h1010101 << idx;  // DR
  assign masks[3] = 42'h0041041 << idx;  // DL

  assign line_ok[0] = (col <= 3'd3);
  assign line_ok[1] = (row <= 3'd2);
  assign line_ok[2] = (row <= 3'd2) && (col <= 3'd3);
  assign line_ok[3] = (row <= 3'd2) && (col >= 3'd3);

  assign start     = (state == IDLE) && FT && !ft_prev;
  assign last_cell = (idx == 6'd41);
  assign busy      = (state == SCAN);
  assign done      = (state == DONE);

  // Walk candidates from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    hit       = 1'b0;
    hit_owner = 1'b0;
    hit_mask  = '0;
    for (int i = 3; i >= 0; i--) begin
      if (line_ok[i] && ((snap_tab & masks[i]) == masks[i]) &&
          (((snap_fic & masks[i]) == masks[i]) || ((snap_fic & masks[i]) == '0))) begin
        hit       = 1'b1;
        hit_mask  = masks[i];
        hit_owner = snap_fic[idx];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (hit || last_cell) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      ft_prev       <= 1'b0;
      snap_tab      <= '0;
      snap_fic      <= '0;
      idx           <= '0;
      row           <= '0;
      col           <= '0;
      gano          <= 1'b0;
      ganador       <= 1'b0;
      empate        <= 1'b0;
      lineaGanadora <= '0;
    end else begin
      state   <= state_nx;
      ft_prev <= FT;
      case (state)
        IDLE: begin
          if (start) begin
            snap_tab      <= tablero;
            snap_fic      <= fichas;
            idx           <= '0;
            row           <= '0;
            col           <= '0;
            gano          <= 1'b0;
            ganador       <= 1'b0;
            empate        <= 1'b0;
            lineaGanadora <= '0;
          end
        end
        SCAN: begin
          if (hit) begin
            gano          <= 1'b1;
            ganador       <= hit_owner;
            lineaGanadora <= hit_mask;
            empate        <= 1'b0;
          end else if (last_cell) begin
            gano          <= 1'b0;
            lineaGanadora <= '0;
            empate        <= &snap_tab;
          end else begin
            idx <= idx + 6'd1;
            if (col == 3'd6) begin
              col <= '0;
              row <= row + 3'd1;
            end else begin
              col <= col + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_detector_ganador.sv
// Randomized and directed bench for detector_ganador against a coordinate-based
// reference model of the win/draw rules.
module tb_detector_ganador;

  logic            clk = 1'b0;
  logic            reset;
  logic            FT;
  logic [5:0][6:0] tablero, fichas;
  logic            busy, done, gano, ganador, empate;
  logic [5:0][6:0] lineaGanadora;

  int n_checks = 0;
  int n_fail   = 0;

  detector_ganador dut (
    .clk(clk), .reset(reset), .FT(FT), .tablero(tablero), .fichas(fichas),
    .busy(busy), .done(done), .gano(gano), .ganador(ganador), .empate(empate),
    .lineaGanadora(lineaGanadora)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: try every start cell in scan order, every direction in priority order.
  task automatic model(input logic [5:0][6:0] t, input logic [5:0][6:0] f,
                       output logic g, output logic w, output logic e,
                       output logic [5:0][6:0] ln, output int kk);
    int drs[4];
    int dcs[4];
    drs = '{0, 1, 1, 1};
    dcs = '{1, 0, 1, -1};
    g = 1'b0; w = 1'b0; ln = '0; kk = 42;
    for (int k = 0; k < 42 && !g; k++) begin
      int r;
      int c;
      r = k / 7;
      c = k % 7;
      for (int d = 0; d < 4 && !g; d++) begin
        int er;
        int ec;
        logic ok;
        er = r + 3 * drs[d];
        ec = c + 3 * dcs[d];
        if (er <= 5 && ec >= 0 && ec <= 6) begin
          ok = 1'b1;
          for (int n = 0; n < 4; n++)
            if (!t[r + n * drs[d]][c + n * dcs[d]] || f[r + n * drs[d]][c + n * dcs[d]] != f[r][c])
              ok = 1'b0;
          if (ok) begin
            g = 1'b1;
            w = f[r][c];
            kk = k;
            for (int n = 0; n < 4; n++) ln[r + n * drs[d]][c + n * dcs[d]] = 1'b1;
          end
        end
      end
    end
    e = g ? 1'b0 : (&t);
  endtask

  task automatic run_scan(input logic [5:0][6:0] t, input logic [5:0][6:0] f, input string tag);
    logic eg, ew, ee;
    logic [5:0][6:0] el;
    int ek, exp_lat, got_lat;
    logic [63:0] r64;
    model(t, f, eg, ew, ee, el, ek);
    exp_lat = eg ? ek + 1 : 42;
    @(negedge clk);
    tablero = t; fichas = f; FT = 1'b1;
    @(posedge clk); #1;
    check({tag, ":busy_start"}, 64'(busy), 64'd1);
    got_lat = 0;
    for (int cyc = 1; cyc <= 60 && got_lat == 0; cyc++) begin
      @(negedge clk);
      FT = (cyc == 3 && exp_lat >= 5);  // ignored retrigger while scanning
      if (cyc == 1) begin
        r64 = {$urandom, $urandom}; tablero = r64[41:0];
        r64 = {$urandom, $urandom}; fichas  = r64[41:0];
      end
      @(posedge clk); #1;
      if (done) got_lat = cyc;
    end
    check({tag, ":latency"}, 64'(got_lat), 64'(exp_lat));
    check({tag, ":busy_done"}, 64'(busy), 64'd0);
    check({tag, ":gano"}, 64'(gano), 64'(eg));
    if (eg) check({tag, ":ganador"}, 64'(ganador), 64'(ew));
    check({tag, ":empate"}, 64'(empate), 64'(ee));
    check({tag, ":linea"}, 64'(lineaGanadora), 64'(el));
    @(negedge clk);
    FT = 1'b0;
    @(posedge clk); #1;
    check({tag, ":done_1cyc"}, 64'(done), 64'd0);
    check({tag, ":hold"}, 64'({gano, empate, lineaGanadora}), 64'({eg, ee, el}));
  endtask

  function automatic logic [5:0][6:0] rand_fichas();
    logic [63:0] r64;
    r64 = {$urandom, $urandom};
    return r64[41:0];
  endfunction

  logic [5:0][6:0] t, f;
  int dones, first_done;

  initial begin
    reset = 1'b0; FT = 1'b0; tablero = '0; fichas = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({busy, done, gano, ganador, empate, lineaGanadora}), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Horizontal, player 1, row 0 cols 0..3
    t = '0; f = '0;
    for (int c = 0; c < 4; c++) begin t[0][c] = 1'b1; f[0][c] = 1'b1; end
    run_scan(t, f, "horiz");
    check("horiz_row0", 64'(lineaGanadora[0]), 64'h0F);

    // Vertical, player 0 col 6 rows 0..3; player 1 row 0 cols 0..2
    t = '0; f = '0;
    for (int r = 0; r < 4; r++) t[r][6] = 1'b1;
    for (int c = 0; c < 3; c++) begin t[0][c] = 1'b1; f[0][c] = 1'b1; end
    run_scan(t, f, "vert");

    // DL diagonal for player 1 with player 0 filler underneath
    t = '0; f = '0;
    for (int n = 0; n < 4; n++) begin
      t[n][6 - n] = 1'b1; f[n][6 - n] = 1'b1;
      for (int r = 0; r < n; r++) t[r][6 - n] = 1'b1;
    end
    run_scan(t, f, "diag_dl");

    // Full board draw, owner = (col/2 + row) mod 2, then one cell emptied
    t = '1; f = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) f[r][c] = 1'((c / 2 + r) % 2);
    run_scan(t, f, "draw");
    check("draw_flag", 64'(empate), 64'd1);
    t[5][3] = 1'b0;
    run_scan(t, f, "nearly_full");

    // Masking: owners all ones on an empty board, FT held high
    @(negedge clk);
    tablero = '0; fichas = '1; FT = 1'b1;
    dones = 0; first_done = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (first_done == 0) first_done = cyc;
      end
    end
    check("mask_done_count", 64'(dones), 64'd1);
    check("mask_latency", 64'(first_done), 64'd42);
    check("mask_result", 64'({gano, empate}), 64'd0);
    @(negedge clk);
    FT = 1'b0;

    // Reset in the middle of a scan that would win at cell 21
    t = '0; f = '0;
    for (int c = 0; c < 4; c++) begin t[3][c] = 1'b1; f[3][c] = 1'b1; end
    @(negedge clk);
    tablero = t; fichas = f; FT = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc < 10; cyc++) begin
      @(negedge clk); FT = 1'b0;
      @(posedge clk);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("midscan_reset", 64'({busy, done, gano, ganador, empate, lineaGanadora}), 64'd0);
    @(negedge clk); reset = 1'b1;
    dones = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midscan_no_done", 64'(dones), 64'd0);
    run_scan(t, f, "after_reset");

    // Random gravity-filled boards with garbage owners in empty cells
    for (int it = 0; it < 25; it++) begin
      t = '0;
      f = rand_fichas();
      for (int c = 0; c < 7; c++) begin
        int h;
        h = $urandom_range(0, 6);
        for (int r = 0; r < h; r++) t[r][c] = 1'b1;
      end
      run_scan(t, f, $sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
